// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the arbitrated ALU: FSM states, default widths and opcode map.
package alu_arbiter_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_OP_W   = 4;

  // Opcode 0 is reserved as the illegal operation.
  localparam int OP_ILLEGAL = 0;
  localparam int OP_ADD     = 1;
  localparam int OP_SUB     = 2;
  localparam int OP_AND     = 3;
  localparam int OP_OR      = 4;
  localparam int OP_XOR     = 5;
  localparam int OP_SLL     = 6;
  localparam int OP_SRL     = 7;
  localparam int OP_SRA     = 8;
  localparam int OP_SLT     = 9;
  localparam int OP_SLTU    = 10;
  localparam int OP_PASS_B  = 11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational ALU shared by all requesters; flags are derived from the result.
module alu_arbiter_alu
  import alu_arbiter_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int OP_W   = DEF_OP_W
) (
  input  logic signed [DATA_W-1:0] operand_1,
  input  logic signed [DATA_W-1:0] operand_2,
  input  logic        [OP_W-1:0]   op,
  output logic signed [DATA_W-1:0] out,
  output logic                     negative,
  output logic                     zero
);

  localparam int SH_W = $clog2(DATA_W);

  logic [SH_W-1:0] shamt;

  assign shamt = operand_2[SH_W-1:0];

  always_comb begin
    out = '0;
    case (op)
      OP_W'(OP_ADD):    out = operand_1 + operand_2;
      OP_W'(OP_SUB):    out = operand_1 - operand_2;
      OP_W'(OP_AND):    out = operand_1 & operand_2;
      OP_W'(OP_OR):     out = operand_1 | operand_2;
      OP_W'(OP_XOR):    out = operand_1 ^ operand_2;
      OP_W'(OP_SLL):    out = operand_1 << shamt;
      OP_W'(OP_SRL):    out = $signed($unsigned(operand_1) >> shamt);
      OP_W'(OP_SRA):    out = operand_1 >>> shamt;
      OP_W'(OP_SLT):    out = {{(DATA_W-1){1'b0}}, (operand_1 < operand_2)};
      OP_W'(OP_SLTU):   out = {{(DATA_W-1){1'b0}}, ($unsigned(operand_1) < $unsigned(operand_2))};
      OP_W'(OP_PASS_B): out = operand_2;
      default:          out = '0;
    endcase
  end

  assign negative = out[DATA_W-1];
  assign zero     = (out == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter granting NUM_REQ requesters access to one ALU, one operation in flight.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int OP_W    = DEF_OP_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  input  logic [NUM_REQ*OP_W-1:0]   req_op,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [id_width(NUM_REQ)-1:0] resp_id,
  output logic [DATA_W-1:0]         resp_data,
  output logic                      resp_negative,
  output logic                      resp_zero,
  output logic                      resp_err,
  output logic [15:0]               op_count
);

  localparam int ID_W = id_width(NUM_REQ);

  state_e state_q, state_d;

  logic [ID_W-1:0] rr_ptr_q;
  logic [ID_W-1:0] grant_idx;
  logic            grant_found;
  logic [ID_W:0]   cand;
  logic            hs;
  logic            resp_hs;
  logic [15:0]     op_count_q;

  logic signed [DATA_W-1:0] sel_a, sel_b;
  logic        [OP_W-1:0]   sel_op;

  logic signed [DATA_W-1:0] a_p0, b_p0;
  logic        [OP_W-1:0]   op_p0;
  logic        [ID_W-1:0]   id_p0;

  logic signed [DATA_W-1:0] alu_out;
  logic                     alu_neg, alu_zero;

  logic signed [DATA_W-1:0] res_p1;
  logic                     neg_p1, zero_p1, err_p1;

  // Search from rr_ptr upward; the first valid requester wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
      if (cand >= (ID_W+1)'(NUM_REQ)) cand = cand - (ID_W+1)'(NUM_REQ);
      if (!grant_found && req_valid[cand[ID_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[ID_W-1:0];
      end
    end
  end

  assign hs        = rst_n && (state_q == ST_IDLE) && grant_found;
  assign req_ready = hs ? (NUM_REQ'(1) << grant_idx) : '0;
  assign resp_hs   = (state_q == ST_RESP) && resp_ready;

  always_comb begin
    sel_a  = req_a[int'(grant_idx)*DATA_W +: DATA_W];
    sel_b  = req_b[int'(grant_idx)*DATA_W +: DATA_W];
    sel_op = req_op[int'(grant_idx)*OP_W +: OP_W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (hs) state_d = ST_EXEC;
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: if (resp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Stage p0: operands captured at the request handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_p0  <= '0;
      b_p0  <= '0;
      op_p0 <= '0;
      id_p0 <= '0;
    end else if (hs) begin
      a_p0  <= sel_a;
      b_p0  <= sel_b;
      op_p0 <= sel_op;
      id_p0 <= grant_idx;
    end
  end

  alu_arbiter_alu #(
    .DATA_W(DATA_W),
    .OP_W  (OP_W)
  ) u_alu (
    a_p0,
    b_p0,
    op_p0,
    alu_out,
    alu_neg,
    alu_zero
  );

  // Stage p1: result and flags registered at the end of EXEC, held through RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_p1  <= '0;
      neg_p1  <= 1'b0;
      zero_p1 <= 1'b0;
      err_p1  <= 1'b0;
    end else if (state_q == ST_EXEC) begin
      if (op_p0 == OP_W'(OP_ILLEGAL)) begin
        res_p1  <= '0;
        neg_p1  <= 1'b0;
        zero_p1 <= 1'b0;
        err_p1  <= 1'b1;
      end else begin
        res_p1  <= alu_out;
        neg_p1  <= alu_neg;
        zero_p1 <= alu_zero;
        err_p1  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q   <= '0;
      op_count_q <= '0;
    end else if (resp_hs) begin
      rr_ptr_q   <= (id_p0 == ID_W'(NUM_REQ-1)) ? '0 : id_p0 + ID_W'(1);
      op_count_q <= op_count_q + 16'd1;
    end
  end

  assign resp_valid    = (state_q == ST_RESP);
  assign resp_id       = id_p0;
  assign resp_data     = res_p1;
  assign resp_negative = neg_p1;
  assign resp_zero     = zero_p1;
  assign resp_err      = err_p1;
  assign op_count      = op_count_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: directed operations, contention, backpressure, reset and wrap.
module tb_alu_arbiter;

  localparam int NR = 2;
  localparam int DW = 32;
  localparam int OW = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NR-1:0]   req_valid;
  logic [NR*DW-1:0] req_a, req_b;
  logic [NR*OW-1:0] req_op;
  logic [NR-1:0]   req_ready;
  logic            resp_valid, resp_ready;
  logic [0:0]      resp_id;
  logic [DW-1:0]   resp_data;
  logic            resp_negative, resp_zero, resp_err;
  logic [15:0]     op_count;

  typedef struct packed {
    logic [0:0]    id;
    logic [DW-1:0] data;
    logic          neg;
    logic          zero;
    logic          err;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_cnt;

  alu_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .OP_W(OW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_op       (req_op),
    .req_ready    (req_ready),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_id      (resp_id),
    .resp_data    (resp_data),
    .resp_negative(resp_negative),
    .resp_zero    (resp_zero),
    .resp_err     (resp_err),
    .op_count     (op_count)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endfunction

  // Monitor: every accepted response is matched against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && resp_valid && resp_ready) begin
      exp_t e;
      exp_t act;
      act = {resp_id, resp_data, resp_negative, resp_zero, resp_err};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL resp_unexpected got id=%0d data=%h expected no response", resp_id, resp_data);
      end else begin
        e = exp_q.pop_front();
        if (act !== e) begin
          errors++;
          $display("FAIL resp_match got id=%0d data=%h n=%b z=%b e=%b expected id=%0d data=%h n=%b z=%b e=%b",
                   act.id, act.data, act.neg, act.zero, act.err, e.id, e.data, e.neg, e.zero, e.err);
        end
      end
    end
  end

  task automatic do_op(input int id, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [OW-1:0] op, input logic [DW-1:0] ed, input logic en,
                       input logic ez, input logic ee, input int bp);
    exp_t e;
    e.id = 1'(id); e.data = ed; e.neg = en; e.zero = ez; e.err = ee;
    exp_q.push_back(e);
    req_a[id*DW +: DW] = a;
    req_b[id*DW +: DW] = b;
    req_op[id*OW +: OW] = op;
    req_valid = '0;
    req_valid[id] = 1'b1;
    resp_ready = (bp == 0);
    @(negedge clk);
    chk("grant_onehot", 64'(req_ready), 64'(1 << id));
    @(posedge clk); #1;
    req_valid = (bp > 0) ? 2'b11 : 2'b00;
    req_a = '1; req_b = '1; req_op = '1;
    @(negedge clk);
    chk("exec_no_resp", 64'(resp_valid), 64'(0));
    chk("exec_no_ready", 64'(req_ready), 64'(0));
    @(negedge clk);
    chk("latency_resp_valid", 64'(resp_valid), 64'(1));
    for (int i = 0; i < bp; i++) begin
      chk("stall_valid", 64'(resp_valid), 64'(1));
      chk("stall_data", 64'(resp_data), 64'(ed));
      chk("stall_ready_zero", 64'(req_ready), 64'(0));
      chk("stall_op_count", 64'(op_count), 64'(exp_cnt));
      @(posedge clk); #1;
      if (i == bp - 1) begin
        req_valid = '0;
        resp_ready = 1'b1;
      end
      @(negedge clk);
    end
    @(posedge clk); #1;
    exp_cnt = exp_cnt + 16'd1;
    chk("op_count", 64'(op_count), 64'(exp_cnt));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int grants;
    rst_n = 1'b0; req_valid = 2'b11; req_a = '0; req_b = '0; req_op = '0;
    resp_ready = 1'b0; exp_cnt = '0;
    repeat (2) @(negedge clk);
    chk("reset_req_ready", 64'(req_ready), 64'(0));
    chk("reset_resp_valid", 64'(resp_valid), 64'(0));
    chk("reset_op_count", 64'(op_count), 64'(0));
    chk("reset_resp_fields", 64'({resp_id, resp_data, resp_negative, resp_zero, resp_err}), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1; req_valid = '0;

    do_op(0, 32'd15, 32'd42, 4'd1, 32'd57, 1'b0, 1'b0, 1'b0, 0);
    do_op(1, 32'd5, 32'd7, 4'd2, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0, 0);
    do_op(0, 32'h0000_F0F0, 32'h0000_0FF0, 4'd3, 32'h0000_00F0, 1'b0, 1'b0, 1'b0, 0);
    do_op(1, 32'h1234, 32'h1234, 4'd5, 32'd0, 1'b0, 1'b1, 1'b0, 0);
    do_op(0, 32'h8000_0000, 32'd4, 4'd8, 32'hF800_0000, 1'b1, 1'b0, 1'b0, 0);
    do_op(1, 32'hFFFF_FFFF, 32'd1, 4'd9, 32'd1, 1'b0, 1'b0, 1'b0, 0);
    do_op(0, 32'd7, 32'd8, 4'd0, 32'd0, 1'b0, 1'b0, 1'b1, 0);
    do_op(1, 32'd100, 32'd200, 4'd1, 32'd300, 1'b0, 1'b0, 1'b0, 5);
    do_op(0, 32'hFFFF_FFFF, 32'd1, 4'd1, 32'd0, 1'b0, 1'b1, 1'b0, 0);

    // rr_ptr is now 1; launch an op on requester 0 and reset it during EXEC.
    req_a[31:0] = 32'd9; req_b[31:0] = 32'd9; req_op[3:0] = 4'd1;
    req_valid = 2'b01; resp_ready = 1'b1;
    @(negedge clk);
    chk("pre_reset_grant", 64'(req_ready), 64'(1));
    @(posedge clk); #1;
    req_valid = 2'b11;
    rst_n = 1'b0;
    exp_cnt = '0;
    @(negedge clk);
    chk("midexec_reset_resp_valid", 64'(resp_valid), 64'(0));
    chk("midexec_reset_op_count", 64'(op_count), 64'(0));
    chk("midexec_reset_req_ready", 64'(req_ready), 64'(0));
    chk("midexec_reset_fields", 64'({resp_data, resp_zero, resp_err}), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;

    req_a = {32'd10, 32'd1}; req_b = {32'd3, 32'd2}; req_op = {4'd2, 4'd1};
    for (int i = 0; i < 4; i++) begin
      exp_t e;
      e.id = 1'(i % 2);
      e.data = (i % 2 == 0) ? 32'd3 : 32'd7;
      e.neg = 1'b0; e.zero = 1'b0; e.err = 1'b0;
      exp_q.push_back(e);
    end
    grants = 0;
    for (int c = 0; c < 40 && grants < 4; c++) begin
      @(negedge clk);
      if (c == 0) chk("first_grant_after_reset", 64'(req_ready), 64'(1));
      if (req_ready != '0) begin
        chk("contend_grant", 64'(req_ready), (grants % 2 == 0) ? 64'(1) : 64'(2));
        grants++;
      end
      @(posedge clk); #1;
      if (grants == 4) req_valid = '0;
    end
    chk("contend_grant_count", 64'(grants), 64'(4));
    repeat (6) @(posedge clk);
    #1;
    chk("contend_drained", 64'(exp_q.size()), 64'(0));
    chk("contend_op_count", 64'(op_count), 64'(4));
    exp_cnt = 16'd4;

    @(negedge clk);
    force dut.op_count_q = 16'hFFFE;
    #1;
    release dut.op_count_q;
    exp_cnt = 16'hFFFE;
    @(posedge clk); #1;
    do_op(1, 32'd3, 32'd5, 4'd4, 32'd7, 1'b0, 1'b0, 1'b0, 0);
    do_op(0, 32'd6, 32'd3, 4'd6, 32'd48, 1'b0, 1'b0, 1'b0, 0);
    chk("wrap_to_zero", 64'(op_count), 64'(0));

    repeat (3) @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 2, number of requesters sharing the ALU (2..4).
REQ-002 Parameter DATA_W, default 32, operand/result width.
REQ-003 Parameter OP_W, default 4, ALU operation code width.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 req_valid  input  NUM_REQ  per-requester operation request.
REQ-007 req_a  input  NUM_REQ*DATA_W  packed first operands; requester i in slice i.
REQ-008 req_b  input  NUM_REQ*DATA_W  packed second operands.
REQ-009 req_op  input  NUM_REQ*OP_W  packed operation codes.
REQ-010 req_ready  output  NUM_REQ  one-hot accept strobe; handshake on req_valid[i] & req_ready[i].
REQ-011 resp_valid  output  1  result available.
REQ-012 resp_ready  input  1  consumer accepts result.
REQ-013 resp_id  output  $clog2(NUM_REQ) (min 1)  index of requester owning the result.
REQ-014 resp_data  output  DATA_W  ALU result.
REQ-015 resp_negative  output  1  ALU negative flag.
REQ-016 resp_zero  output  1  ALU zero flag.
REQ-017 resp_err  output  1  illegal opcode (op == 0) flag.
REQ-018 op_count  output  16  completed-operation counter.

Function
REQ-019 FSM states IDLE, EXEC, RESP; only one operation in flight.
REQ-020 IDLE: grant the first requester with req_valid set, searching from rr_ptr upward modulo NUM_REQ; req_ready asserted combinationally for that requester only.
REQ-021 req_ready all-zero in EXEC and RESP, and in IDLE when no req_valid set.
REQ-022 Handshake in IDLE: capture operands, op and grant index into registers; next state EXEC.
REQ-023 EXEC (exactly one cycle): ALU driven from captured registers; result, negative, zero registered at end of cycle; next state RESP.
REQ-024 Captured op == 0: ALU output ignored; resp_data = 0, resp_negative = 0, resp_zero = 0, resp_err = 1.
REQ-025 RESP: resp_valid = 1, resp_id = granted index; all resp_* stable until resp_valid & resp_ready.
REQ-026 RESP with resp_ready: next state IDLE; rr_ptr <= (granted index + 1) mod NUM_REQ; op_count increments by 1.
REQ-027 Latency: handshake at edge T gives resp_valid at T+2; with resp_ready held high, one operation per 3 cycles.
REQ-028 op_count wraps 16'hFFFF -> 16'h0000; err operations also counted.
REQ-029 req_* changes after the handshake do not affect the in-flight result.
REQ-030 Simultaneous requests: exactly one granted; a requester held valid is granted within NUM_REQ operations (no starvation).

Reset
REQ-031 rst_n low at any time, including mid-operation: state IDLE, rr_ptr 0, op_count 0, resp_valid 0, resp_data 0, resp_negative 0, resp_zero 0, resp_err 0, resp_id 0, captured registers 0; in-flight operation discarded.
REQ-032 req_ready all-zero while rst_n low; first grant possible in the first cycle after deassertion.

Structure
REQ-033 Shared package holds FSM state enum, DATA_W/OP_W defaults, illegal-opcode constant (0).
REQ-034 One sub-module instance: the existing ALU (operand 1, operand 2, op, out, negative, zero), ports by order as the ALU defines.

Verification
REQ-035 Single request: req_valid[0], a=32'd15, b=32'd42, op=4'd1 -> ready[0] that cycle; resp_valid 2 cycles later, resp_id 0, resp_data/flags identical to standalone ALU(15,42,1).
REQ-036 Contention: req_valid=2'b11 held, resp_ready=1 -> grants alternate 0,1,0,1; resp_id sequence 0,1,0,1; op_count 4.
REQ-037 Backpressure: resp_ready=0 for 5 cycles in RESP -> resp_* stable, req_ready 0; op_count unchanged until the accept.
REQ-038 Illegal op: op=4'd0, a=7, b=8 -> resp_err 1, resp_data 0, resp_zero 0, resp_negative 0.
REQ-039 Reset mid-EXEC: rst_n low one cycle -> resp_valid 0, op_count 0, next grant to requester 0.
REQ-040 Wrap: force 65536 completed ops -> op_count returns to 0.
